// File: rtl/sram_arbiter.sv
// sram_arbiter: single-clock arbiter and pin driver for a 16-bit asynchronous SRAM.
// A write port (recorder) and a read port (DSP) each own a 1-deep pending slot;
// the FSM serves one access at a time and drives the SRAM pins from registers.
// Optional feature: define SRAM_ARB_RR_EN for round-robin tie-breaking between
// the ports; without it, writes have fixed priority over reads.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_stb,
    input  logic [19:0] i_wr_addr,
    input  logic [15:0] i_wr_data,
    output logic        o_wr_ack,
    input  logic        i_rd_stb,
    input  logic [19:0] i_rd_addr,
    output logic [15:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_busy,
    output logic [1:0]  o_ovf,
    output logic [19:0] o_SRAM_ADDR,
    inout  logic [15:0] io_SRAM_DQ,
    output logic        o_SRAM_WE_N,
    output logic        o_SRAM_OE_N,
    output logic        o_SRAM_CE_N,
    output logic        o_SRAM_LB_N,
    output logic        o_SRAM_UB_N
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RD_ACC,
        ST_RD_DONE
    } state_t;

    // Strobe timer reload: the strobe state lasts WAIT_CYCLES cycles (count W-1 down to 0)
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;

    // Pending slots
    logic        wr_vld;
    logic [19:0] wr_addr_q;
    logic [15:0] wr_data_q;
    logic        rd_vld;
    logic [19:0] rd_addr_q;

    // Data bus driver
    logic [15:0] dq_out;
    logic        dq_oe;

    // Grants are only issued from IDLE
    logic        grant_wr;
    logic        grant_rd;

`ifdef SRAM_ARB_RR_EN
    // 1 = the most recent tie was granted to the write port
    logic        rr_last_wr;
`endif

    assign o_SRAM_CE_N = 1'b0;
    assign o_SRAM_LB_N = 1'b0;
    assign o_SRAM_UB_N = 1'b0;

    assign io_SRAM_DQ = dq_oe ? dq_out : 'z;

    // Arbitration: pick which pending slot (if any) the IDLE state drains this cycle
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == ST_IDLE) begin
            if (wr_vld && rd_vld) begin
`ifdef SRAM_ARB_RR_EN
                if (rr_last_wr) begin
                    grant_rd = 1'b1;
                end else begin
                    grant_wr = 1'b1;
                end
`else
                grant_wr = 1'b1;
`endif
            end else if (wr_vld) begin
                grant_wr = 1'b1;
            end else if (rd_vld) begin
                grant_rd = 1'b1;
            end
        end
    end

`ifdef SRAM_ARB_RR_EN
    // Tie-break pointer: only ties move it, so consecutive ties alternate
    // regardless of how many uncontested accesses happen in between
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_last_wr <= 1'b0;
        end else if (state == ST_IDLE && wr_vld && rd_vld) begin
            rr_last_wr <= grant_wr;
        end
    end
`endif

    // Pending slots: load on strobe, drain on grant, flag a strobe into a full undrained slot
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_vld    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_vld    <= 1'b0;
            rd_addr_q <= '0;
            o_ovf     <= '0;
        end else begin
            if (i_wr_stb && (!wr_vld || grant_wr)) begin
                wr_vld    <= 1'b1;
                wr_addr_q <= i_wr_addr;
                wr_data_q <= i_wr_data;
            end else if (i_wr_stb) begin
                o_ovf[0] <= 1'b1;
            end else if (grant_wr) begin
                wr_vld <= 1'b0;
            end

            if (i_rd_stb && (!rd_vld || grant_rd)) begin
                rd_vld    <= 1'b1;
                rd_addr_q <= i_rd_addr;
            end else if (i_rd_stb) begin
                o_ovf[1] <= 1'b1;
            end else if (grant_rd) begin
                rd_vld <= 1'b0;
            end
        end
    end

    // Access FSM: every pin and status output is a register updated with the state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            o_SRAM_ADDR <= '0;
            dq_out      <= '0;
            dq_oe       <= 1'b0;
            o_SRAM_WE_N <= 1'b1;
            o_SRAM_OE_N <= 1'b1;
            o_wr_ack    <= 1'b0;
            o_rd_valid  <= 1'b0;
            o_rd_data   <= '0;
            o_busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_wr) begin
                        state       <= ST_WR_SETUP;
                        o_SRAM_ADDR <= wr_addr_q;
                        dq_out      <= wr_data_q;
                        dq_oe       <= 1'b1;
                        o_busy      <= 1'b1;
                    end else if (grant_rd) begin
                        state       <= ST_RD_ACC;
                        o_SRAM_ADDR <= rd_addr_q;
                        o_SRAM_OE_N <= 1'b0;
                        cnt         <= CNT_LOAD;
                        o_busy      <= 1'b1;
                    end
                end
                ST_WR_SETUP: begin
                    state       <= ST_WR_PULSE;
                    o_SRAM_WE_N <= 1'b0;
                    cnt         <= CNT_LOAD;
                end
                ST_WR_PULSE: begin
                    if (cnt == 4'd0) begin
                        state       <= ST_WR_HOLD;
                        o_SRAM_WE_N <= 1'b1;
                        o_wr_ack    <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_WR_HOLD: begin
                    state    <= ST_IDLE;
                    o_wr_ack <= 1'b0;
                    dq_oe    <= 1'b0;
                    o_busy   <= 1'b0;
                end
                ST_RD_ACC: begin
                    if (cnt == 4'd0) begin
                        state       <= ST_RD_DONE;
                        o_SRAM_OE_N <= 1'b1;
                        o_rd_data   <= io_SRAM_DQ;
                        o_rd_valid  <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RD_DONE: begin
                    state      <= ST_IDLE;
                    o_rd_valid <= 1'b0;
                    o_busy     <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    dq_oe       <= 1'b0;
                    o_SRAM_WE_N <= 1'b1;
                    o_SRAM_OE_N <= 1'b1;
                    o_wr_ack    <= 1'b0;
                    o_rd_valid  <= 1'b0;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: self-checking bench for sram_arbiter with a behavioural SRAM
// model, cycle tables for single write/read, directed corner sequences and a
// randomised scoreboard run.
module tb_sram_arbiter;

    typedef struct packed {
        logic we_n;
        logic oe_n;
        logic dq_oe;
        logic ack;
        logic rv;
        logic busy;
        logic chk_addr;
        logic chk_dq;
    } row_t;

    typedef struct {
        logic [19:0] addr;
        logic [15:0] data;
    } req_t;

    logic        clk;
    logic        rst;
    logic        wr_stb;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        rd_stb;
    logic [19:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic [1:0]  ovf;
    logic [19:0] sram_addr;
    tri   [15:0] sram_dq;
    logic        we_n;
    logic        oe_n;
    logic        ce_n;
    logic        lb_n;
    logic        ub_n;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned ack_cnt = 0;
    int unsigned rv_cnt = 0;
    logic        mon_en = 1'b0;
    logic        mem_init = 1'b0;

    req_t        wr_q[$];
    req_t        rd_q[$];
    bit          order_q[$];

    logic [15:0] mem    [1024];
    logic [15:0] shadow [1024];

    row_t        wr_tab [7];
    row_t        rd_tab [7];

    sram_arbiter #(.WAIT_CYCLES(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_stb    (wr_stb),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_wr_ack    (wr_ack),
        .i_rd_stb    (rd_stb),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .o_busy      (busy),
        .o_ovf       (ovf),
        .o_SRAM_ADDR (sram_addr),
        .io_SRAM_DQ  (sram_dq),
        .o_SRAM_WE_N (we_n),
        .o_SRAM_OE_N (oe_n),
        .o_SRAM_CE_N (ce_n),
        .o_SRAM_LB_N (lb_n),
        .o_SRAM_UB_N (ub_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int unsigned i);
        if (i == 32'h10) return 16'hA5C3;
        return 16'h5A00 ^ 16'(i);
    endfunction

    // SRAM model: drives DQ while OE_N is low, stores on clock edges while WE_N is low
    assign sram_dq = (!oe_n && we_n) ? mem[sram_addr[9:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int unsigned i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else if (!we_n) begin
            mem[sram_addr[9:0]] <= sram_dq;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // Monitor: bus-safety invariants every cycle, plus scoreboard pops on ack/valid
    always @(negedge clk) begin
        req_t e;
        if (mem_init) begin
            for (int unsigned i = 0; i < 1024; i++) shadow[i] = init_word(i);
        end
        if (mon_en) begin
            check("we_oe_both_low", {31'b0, we_n | oe_n}, 32'd1);
            check("dq_driven_during_read", {31'b0, dut.dq_oe & ~oe_n}, 32'd0);
            check("dq_driven_while_idle", {31'b0, dut.dq_oe & ~busy}, 32'd0);
            if (wr_ack) begin
                ack_cnt++;
                order_q.push_back(1'b0);
                if (wr_q.size() == 0) begin
                    fail_now("wr_ack_unexpected", "ack with no write outstanding, expected none");
                end else begin
                    e = wr_q.pop_front();
                    check("wr_ack_addr", {12'b0, sram_addr}, {12'b0, e.addr});
                    check("wr_mem_data", {16'b0, mem[e.addr[9:0]]}, {16'b0, e.data});
                    shadow[e.addr[9:0]] = e.data;
                end
            end
            if (rd_valid) begin
                rv_cnt++;
                order_q.push_back(1'b1);
                if (rd_q.size() == 0) begin
                    fail_now("rd_valid_unexpected", "valid with no read outstanding, expected none");
                end else begin
                    e = rd_q.pop_front();
                    check($sformatf("rd_data@%05h", e.addr), {16'b0, rd_data}, {16'b0, e.data});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stb();
        wr_stb = 1'b0;
        rd_stb = 1'b0;
    endtask

    task automatic strobe_wr(input logic [19:0] a, input logic [15:0] d, input bit served);
        wr_stb  = 1'b1;
        wr_addr = a;
        wr_data = d;
        if (served) wr_q.push_back('{a, d});
    endtask

    task automatic strobe_rd(input logic [19:0] a);
        rd_stb  = 1'b1;
        rd_addr = a;
        rd_q.push_back('{a, shadow[a[9:0]]});
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        while ((busy || wr_q.size() != 0 || rd_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) fail_now({tag, "_timeout"}, "arbiter did not drain within 200 cycles");
        tick();
    endtask

    task automatic check_row(input string tag, input int c, input row_t r,
                             input logic [19:0] ea, input logic [15:0] ed);
        check($sformatf("%s_ctl_c%0d", tag, c),
              {26'b0, we_n, oe_n, dut.dq_oe, wr_ack, rd_valid, busy},
              {26'b0, r.we_n, r.oe_n, r.dq_oe, r.ack, r.rv, r.busy});
        if (r.chk_addr) check($sformatf("%s_addr_c%0d", tag, c), {12'b0, sram_addr}, {12'b0, ea});
        if (r.chk_dq)   check($sformatf("%s_dq_c%0d", tag, c), {16'b0, sram_dq}, {16'b0, ed});
    endtask

    initial begin : main
        logic [19:0] a;
        int unsigned base;
        int n;

        //                we oe dq ak rv by ca cd
        wr_tab[0] = 8'b1__1__0__0__0__0__0__0;
        wr_tab[1] = 8'b1__1__0__0__0__0__0__0;
        wr_tab[2] = 8'b1__1__1__0__0__1__1__1;
        wr_tab[3] = 8'b0__1__1__0__0__1__1__1;
        wr_tab[4] = 8'b0__1__1__0__0__1__1__1;
        wr_tab[5] = 8'b1__1__1__1__0__1__1__1;
        wr_tab[6] = 8'b1__1__0__0__0__0__0__0;

        rd_tab[0] = 8'b1__1__0__0__0__0__0__0;
        rd_tab[1] = 8'b1__1__0__0__0__0__0__0;
        rd_tab[2] = 8'b1__0__0__0__0__1__1__0;
        rd_tab[3] = 8'b1__0__0__0__0__1__1__0;
        rd_tab[4] = 8'b1__1__0__0__1__1__0__0;
        rd_tab[5] = 8'b1__1__0__0__0__0__0__0;
        rd_tab[6] = 8'b1__1__0__0__0__0__0__0;

        // Power-on reset and reset values
        rst = 1'b1;
        mem_init = 1'b1;
        wr_stb = 1'b0; wr_addr = '0; wr_data = '0;
        rd_stb = 1'b0; rd_addr = '0;
        repeat (3) tick();
        mem_init = 1'b0;
        @(negedge clk);
        check("reset_ctl", {26'b0, we_n, oe_n, busy, wr_ack, rd_valid, dut.dq_oe}, 32'b110000);
        check("reset_ovf", {30'b0, ovf}, 32'd0);
        check("reset_rd_data", {16'b0, rd_data}, 32'd0);
        check("reset_addr", {12'b0, sram_addr}, 32'd0);
        check("reset_tied_pins", {29'b0, ce_n, lb_n, ub_n}, 32'd0);
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Single write: table-driven cycle check
        strobe_wr(20'h12345, 16'hBEEF, 1'b1);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check_row("wr", c, wr_tab[c], 20'h12345, 16'hBEEF);
            tick();
            clear_stb();
        end
        wait_quiet("wr");

        // Single read of the preloaded word
        strobe_rd(20'h00010);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check_row("rd", c, rd_tab[c], 20'h00010, 16'h0000);
            if (c == 4) check("rd_a5c3", {16'b0, rd_data}, 32'h0000A5C3);
            tick();
            clear_stb();
        end
        wait_quiet("rd");

        // Overflow: strobes in cycles 0,1,2; cycle 1 refills the drained slot, cycle 2 drops
        base = ack_cnt;
        strobe_wr(20'h00400, 16'h0001, 1'b1);
        @(negedge clk);
        tick();
        strobe_wr(20'h00401, 16'h0002, 1'b1);
        @(negedge clk);
        tick();
        strobe_wr(20'h00402, 16'h0003, 1'b0);
        @(negedge clk);
        check("ovf_not_on_refill", {30'b0, ovf}, 32'd0);
        tick();
        clear_stb();
        @(negedge clk);
        check("ovf_on_drop", {30'b0, ovf}, 32'd1);
        tick();
        wait_quiet("ovf");
        repeat (10) tick();
        check("ovf_ack_count", ack_cnt - base, 32'd2);
        check("ovf_dropped_not_written", {16'b0, mem[10'h002]}, {16'b0, init_word(32'h002)});
        check("ovf_sticky", {30'b0, ovf}, 32'd1);

        // Reset in the middle of WR_PULSE, with a refilled write slot and a read strobe under reset
        base = ack_cnt;
        strobe_wr(20'h00200, 16'h1111, 1'b1);
        @(negedge clk);
        tick();
        clear_stb();
        @(negedge clk);
        tick();
        strobe_wr(20'h00201, 16'h2222, 1'b1);
        @(negedge clk);
        tick();
        clear_stb();
        rst = 1'b1;
        rd_stb = 1'b1;
        rd_addr = 20'h00105;
        @(negedge clk);
        check("rst_pre_we_low", {31'b0, we_n}, 32'd0);
        tick();
        rst = 1'b0;
        rd_stb = 1'b0;
        wr_q.delete();
        rd_q.delete();
        @(negedge clk);
        check("rst_ctl", {26'b0, we_n, oe_n, busy, wr_ack, rd_valid, dut.dq_oe}, 32'b110000);
        check("rst_ovf_cleared", {30'b0, ovf}, 32'd0);
        check("rst_addr", {12'b0, sram_addr}, 32'd0);
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            @(negedge clk);
            if (busy) n++;
        end
        check("rst_slots_empty_busy_cycles", n, 32'd0);
        check("rst_no_ack", ack_cnt - base, 32'd0);
        tick();

        // Tie after reset: write first, then read
        order_q.delete();
        strobe_wr(20'h00300, 16'hCAFE, 1'b1);
        strobe_rd(20'h00101);
        tick();
        clear_stb();
        n = 0;
        while (order_q.size() < 2 && n < 60) begin tick(); n++; end
        if (order_q.size() < 2) fail_now("tie1_timeout", "two completions not seen within 60 cycles");
        else check("tie1_order", {30'b0, order_q[0], order_q[1]}, 32'b01);
        wait_quiet("tie1");

        // Second tie: round-robin hands it to the read, fixed priority keeps the write first
        order_q.delete();
        strobe_wr(20'h00301, 16'hBEAD, 1'b1);
        strobe_rd(20'h00300);
        tick();
        clear_stb();
        n = 0;
        while (order_q.size() < 2 && n < 60) begin tick(); n++; end
        if (order_q.size() < 2) begin
            fail_now("tie2_timeout", "two completions not seen within 60 cycles");
        end else begin
`ifdef SRAM_ARB_RR_EN
            check("tie2_order", {30'b0, order_q[0], order_q[1]}, 32'b10);
`else
            check("tie2_order", {30'b0, order_q[0], order_q[1]}, 32'b01);
`endif
        end
        wait_quiet("tie2");

        // Random interleaved traffic; one outstanding request per port, no same-address hazards
        for (int i = 0; i < 10000; i++) begin
            clear_stb();
            if (rd_q.size() == 0 && $urandom_range(0, 2) == 0) begin
                a = 20'h00100 + 20'($urandom_range(0, 7));
                if (!(wr_q.size() != 0 && wr_q[0].addr == a)) strobe_rd(a);
            end
            if (wr_q.size() == 0 && $urandom_range(0, 2) == 0) begin
                a = 20'h00100 + 20'($urandom_range(0, 7));
                if (!(rd_q.size() != 0 && rd_q[0].addr == a)) strobe_wr(a, 16'($urandom), 1'b1);
            end
            tick();
        end
        clear_stb();
        wait_quiet("rand");
        check("rand_no_ovf", {30'b0, ovf}, 32'd0);
        check("rand_some_reads", {31'b0, rv_cnt > 100}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-clock arbiter and pin driver for the 16-bit external SRAM. It sits directly below the top-level recorder/DSP controller and replaces the direct recorder-to-pin wiring. It accepts one-cycle write strobes from the recorder path and one-cycle read strobes from the DSP path, buffers one request per port, and drives the SRAM address, data and control pins. It returns write acknowledges, and read data with a valid pulse.

## Interface
- `WAIT_CYCLES`, default 2: number of cycles the WE_N or OE_N strobe is held low (legal range 1..15).
- `i_clk` in 1: system clock; all logic is on the rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_wr_stb` in 1: one-cycle write request; `i_wr_addr` and `i_wr_data` are sampled in the same cycle.
- `i_wr_addr` in 20: write address.
- `i_wr_data` in 16: write data.
- `o_wr_ack` out 1: one-cycle pulse when the write completes.
- `i_rd_stb` in 1: one-cycle read request; `i_rd_addr` is sampled in the same cycle.
- `i_rd_addr` in 20: read address.
- `o_rd_data` out 16: read data; holds its value until the next read completes.
- `o_rd_valid` out 1: one-cycle pulse; `o_rd_data` is valid in that cycle.
- `o_busy` out 1: high whenever the state is not IDLE.
- `o_ovf` out 2: sticky overflow flags; bit0 = write port, bit1 = read port.
- `o_SRAM_ADDR` out 20: SRAM address.
- `io_SRAM_DQ` inout 16: SRAM data bus.
- `o_SRAM_WE_N`, `o_SRAM_OE_N` out 1: SRAM write enable and output enable.
- `o_SRAM_CE_N`, `o_SRAM_LB_N`, `o_SRAM_UB_N` out 1: tied to 0.

## Operation
- **Pending slots.** Each port has a 1-deep pending slot (valid bit, address, and data for the write port).
  - A strobe loads the port's slot.
  - A strobe that arrives while the slot is valid and not being drained in that same cycle is dropped and sets the port's `o_ovf` bit.
  - A slot drains (is copied to the active registers) in the IDLE cycle that grants it. A strobe in that same cycle refills the slot and does not overflow.
- **States:** IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACC, RD_DONE.
- **IDLE:**
  - Only the write slot valid: go to WR_SETUP.
  - Only the read slot valid: go to RD_ACC.
  - Both valid: arbitration per Configuration.
  - Neither valid: stay in IDLE.
- **WR_SETUP** (1 cycle): address and data are driven onto the pins, WE_N=1, OE_N=1.
- **WR_PULSE** (WAIT_CYCLES cycles): WE_N=0, data still driven.
- **WR_HOLD** (1 cycle): WE_N=1, data still driven, `o_wr_ack`=1. Next state is IDLE.
- **RD_ACC** (WAIT_CYCLES cycles): OE_N=0, DQ is hi-Z. DQ is captured into `o_rd_data` on the clock edge that leaves RD_ACC.
- **RD_DONE** (1 cycle): OE_N=1, `o_rd_valid`=1. Next state is IDLE.
- **DQ driver.** `io_SRAM_DQ` is driven only in WR_SETUP, WR_PULSE and WR_HOLD; it is hi-Z in every other state. WE_N and OE_N are never low simultaneously.
- **Counter.** A 4-bit counter times WR_PULSE and RD_ACC. It reloads on entry to each of those states.
- **Reset.** `i_rst` aborts any access on the next edge.
  - Pins: WE_N=1, OE_N=1, ADDR=0, DQ hi-Z.
  - Registers: both slots cleared, `o_ovf`=0, `o_rd_data`=0, `o_rd_valid`=0, `o_wr_ack`=0, `o_busy`=0, state=IDLE.
  - Round-robin pointer: favours write.
  - Strobes arriving while `i_rst` is high are ignored.

## Timing
- All outputs are registered or decoded from the registered state, so they are glitch-free.
- Write, strobe in cycle 0:
  - Slot valid at cycle 1 (IDLE grants).
  - WR_SETUP at cycle 2.
  - `o_wr_ack` at cycle 3+WAIT_CYCLES.
  - Back in IDLE at cycle 4+WAIT_CYCLES.
- Read, strobe in cycle 0:
  - RD_ACC from cycle 2.
  - `o_rd_valid` at cycle 2+WAIT_CYCLES.
- Service time, IDLE cycle included: a write takes WAIT_CYCLES+3 cycles, a read WAIT_CYCLES+2.
- Sustained throughput with both ports saturated (round-robin): one write plus one read every 2·WAIT_CYCLES+5 cycles.

## Configuration
- `SRAM_ARB_RR_EN` defined: when both slots are valid, the grant alternates. A 1-bit pointer records the last granted port, and the other port wins the tie.
- `SRAM_ARB_RR_EN` undefined: fixed write priority; a read is granted only when the write slot is empty. The pointer logic is not built.

## Test plan
- **Reset.** Assert `i_rst` mid-WR_PULSE. Required on the next edge: WE_N=1, DQ hi-Z, `o_busy`=0, `o_ovf`=0, both slots empty; no `o_wr_ack` follows.
- **Single write.** WAIT_CYCLES=2; write strobe at cycle 0 with addr 0x12345, data 0xBEEF. Required: ADDR=0x12345 and DQ=0xBEEF during cycles 2–5, WE_N=0 in cycles 3–4, `o_wr_ack` in cycle 5.
- **Single read.** SRAM model returns 0xA5C3 at address 0x00010; read strobe at cycle 0. Required: OE_N=0 in cycles 2–3, `o_rd_valid`=1 with `o_rd_data`=0xA5C3 in cycle 4, DQ never driven.
- **Tie.** Both strobes in the same cycle.
  - With `SRAM_ARB_RR_EN`: the write is served first after reset, then the read, and the following tie goes to the read.
  - Without it: the write is always served first.
- **Overflow.** Three write strobes in cycles 0, 1, 2. Required: the cycle-1 strobe refills the slot drained in cycle 1, the cycle-2 strobe is dropped, `o_ovf`=2'b01, exactly two `o_wr_ack` pulses.
- **Bus contention check.** Random interleaved strobes for 10k cycles. Required: WE_N and OE_N are never both low; DQ is driven only while the state is WR_SETUP, WR_PULSE or WR_HOLD; scoreboard read data matches the last data written to each address.
